// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
//
// Two-entry skid buffer at the IF/ID boundary of the pipelined ARMv8 core.
// Each entry carries an instruction word, its PC and its PC+4 link value.
// The main entry drives the decode-side outputs; the skid entry absorbs the
// one extra instruction fetch may issue in the cycle decode stops accepting.
// fetch_ready comes straight from a register so decode backpressure and
// flush never reach the fetch PC write enable combinationally.
//
// Ports:
//   clock               single clock, rising-edge state updates
//   reset               synchronous, active-high
//   instruction_in      instruction word from fetch
//   PC_in               PC of that instruction
//   PC_branch_link_in   PC+4 of that instruction
//   fetch_valid         fetch presents an instruction this cycle
//   fetch_ready         buffer accepts this cycle (fetch PCWrite)
//   flush               redirect: drop every buffered and incoming entry
//   decode_ready        decode consumes the output entry this cycle
//   valid_out           output entry valid
//   instruction_out     output instruction, NOP_INSTR when invalid
//   PC_out              output PC, 0 when invalid
//   PC_branch_link_out  output PC+4, 0 when invalid
//   occupancy           number of valid entries (0..2)
// -----------------------------------------------------------------------------
module if_id_buffer #(
   parameter int          ADDR_WIDTH = 64,
   parameter logic [31:0] NOP_INSTR  = 32'hD503201F
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           instruction_in,
   input  logic [ADDR_WIDTH-1:0] PC_in,
   input  logic [ADDR_WIDTH-1:0] PC_branch_link_in,
   input  logic                  fetch_valid,
   output logic                  fetch_ready,
   input  logic                  flush,
   input  logic                  decode_ready,
   output logic                  valid_out,
   output logic [31:0]           instruction_out,
   output logic [ADDR_WIDTH-1:0] PC_out,
   output logic [ADDR_WIDTH-1:0] PC_branch_link_out,
   output logic [1:0]            occupancy
);

   // Main entry (visible at the outputs)
   logic                  main_valid_reg, main_valid_next;
   logic [31:0]           main_instr_reg, main_instr_next;
   logic [ADDR_WIDTH-1:0] main_pc_reg,    main_pc_next;
   logic [ADDR_WIDTH-1:0] main_link_reg,  main_link_next;

   // Skid entry (only ever valid while main is valid)
   logic                  skid_valid_reg, skid_valid_next;
   logic [31:0]           skid_instr_reg, skid_instr_next;
   logic [ADDR_WIDTH-1:0] skid_pc_reg,    skid_pc_next;
   logic [ADDR_WIDTH-1:0] skid_link_reg,  skid_link_next;

   logic push;
   logic pop;

   // Accept whenever the skid slot is free; a pop cannot reopen the slot in
   // the same cycle, which keeps this a pure function of registered state.
   assign fetch_ready = !skid_valid_reg;
   assign push        = fetch_valid & fetch_ready;
   assign pop         = main_valid_reg & decode_ready;

   always_comb begin
      main_valid_next = main_valid_reg;
      main_instr_next = main_instr_reg;
      main_pc_next    = main_pc_reg;
      main_link_next  = main_link_reg;
      skid_valid_next = skid_valid_reg;
      skid_instr_next = skid_instr_reg;
      skid_pc_next    = skid_pc_reg;
      skid_link_next  = skid_link_reg;

      if (flush) begin
         // Any same-cycle pop is already consumed by decode; the push is dropped.
         main_valid_next = 1'b0;
         skid_valid_next = 1'b0;
      end else if (skid_valid_reg) begin
         // FULL: fetch is stalled, only a pop can change state.
         if (pop) begin
            main_instr_next = skid_instr_reg;
            main_pc_next    = skid_pc_reg;
            main_link_next  = skid_link_reg;
            skid_valid_next = 1'b0;
         end
      end else if (main_valid_reg) begin
         // ONE
         if (push && pop) begin
            main_instr_next = instruction_in;
            main_pc_next    = PC_in;
            main_link_next  = PC_branch_link_in;
         end else if (push) begin
            skid_valid_next = 1'b1;
            skid_instr_next = instruction_in;
            skid_pc_next    = PC_in;
            skid_link_next  = PC_branch_link_in;
         end else if (pop) begin
            main_valid_next = 1'b0;
         end
      end else begin
         // EMPTY
         if (push) begin
            main_valid_next = 1'b1;
            main_instr_next = instruction_in;
            main_pc_next    = PC_in;
            main_link_next  = PC_branch_link_in;
         end
      end
   end

   // Valid bits are the only state that needs a defined reset value.
   always_ff @(posedge clock) begin
      if (reset) begin
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
      end else begin
         main_valid_reg <= main_valid_next;
         skid_valid_reg <= skid_valid_next;
      end
   end

   // Payload registers are hidden by the output masking while invalid.
   always_ff @(posedge clock) begin
      main_instr_reg <= main_instr_next;
      main_pc_reg    <= main_pc_next;
      main_link_reg  <= main_link_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
      skid_link_reg  <= skid_link_next;
   end

   assign valid_out          = main_valid_reg;
   assign instruction_out    = main_valid_reg ? main_instr_reg : NOP_INSTR;
   assign PC_out             = main_valid_reg ? main_pc_reg    : '0;
   assign PC_branch_link_out = main_valid_reg ? main_link_reg  : '0;
   assign occupancy          = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

endmodule

// File: tb/tb_if_id_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_id_buffer
//
// Self-checking bench for if_id_buffer. A queue holding at most two entries
// models the buffer as a FIFO; every cycle all outputs are compared with the
// head of that queue. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_if_id_buffer;

   localparam int          AW  = 64;
   localparam logic [31:0] NOP = 32'hD503201F;

   logic          clock = 1'b0;
   logic          reset;
   logic [31:0]   instruction_in;
   logic [AW-1:0] PC_in;
   logic [AW-1:0] PC_branch_link_in;
   logic          fetch_valid;
   logic          fetch_ready;
   logic          flush;
   logic          decode_ready;
   logic          valid_out;
   logic [31:0]   instruction_out;
   logic [AW-1:0] PC_out;
   logic [AW-1:0] PC_branch_link_out;
   logic [1:0]    occupancy;

   if_id_buffer #(.ADDR_WIDTH(AW), .NOP_INSTR(NOP)) dut (
      .clock              (clock),
      .reset              (reset),
      .instruction_in     (instruction_in),
      .PC_in              (PC_in),
      .PC_branch_link_in  (PC_branch_link_in),
      .fetch_valid        (fetch_valid),
      .fetch_ready        (fetch_ready),
      .flush              (flush),
      .decode_ready       (decode_ready),
      .valid_out          (valid_out),
      .instruction_out    (instruction_out),
      .PC_out             (PC_out),
      .PC_branch_link_out (PC_branch_link_out),
      .occupancy          (occupancy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0]   ins;
      logic [AW-1:0] pc;
      logic [AW-1:0] link;
   } entry_t;

   entry_t model_q[$];
   int     errors = 0;
   int     checks = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_model();
      bit     v;
      entry_t h;
      v = (model_q.size() != 0);
      if (v) h = model_q[0];
      check_val("valid_out",   {63'd0, valid_out},   {63'd0, v});
      check_val("instr_out",   {32'd0, instruction_out}, v ? {32'd0, h.ins} : {32'd0, NOP});
      check_val("pc_out",      PC_out,              v ? h.pc   : 64'd0);
      check_val("link_out",    PC_branch_link_out,  v ? h.link : 64'd0);
      check_val("occupancy",   {62'd0, occupancy},  64'(model_q.size()));
      check_val("fetch_ready", {63'd0, fetch_ready}, {63'd0, model_q.size() < 2});
   endtask

   // One clock: drive inputs, advance the model, then check after the edge.
   task automatic step(input logic rst, input logic fl, input logic fv, input logic dr,
                       input logic [31:0] ins, input logic [AW-1:0] pc, input logic [AW-1:0] link);
      entry_t e;
      bit     can_push;
      bit     do_pop;
      reset = rst; flush = fl; fetch_valid = fv; decode_ready = dr;
      instruction_in = ins; PC_in = pc; PC_branch_link_in = link;
      if (rst || fl) begin
         model_q.delete();
      end else begin
         can_push = model_q.size() < 2;
         do_pop   = (model_q.size() > 0) && dr;
         if (do_pop) void'(model_q.pop_front());
         if (fv && can_push) begin
            e.ins = ins; e.pc = pc; e.link = link;
            model_q.push_back(e);
         end
      end
      @(posedge clock);
      #1;
      check_model();
      $display("cyc rst=%0b fl=%0b fv=%0b dr=%0b pc_in=%h -> v=%0b pc_out=%h occ=%0d rdy=%0b",
               rst, fl, fv, dr, pc, valid_out, PC_out, occupancy, fetch_ready);
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_valid"}, {63'd0, valid_out},   64'd0);
      check_val({tag, "_instr"}, {32'd0, instruction_out}, {32'd0, NOP});
      check_val({tag, "_pc"},    PC_out,              64'd0);
      check_val({tag, "_link"},  PC_branch_link_out,  64'd0);
      check_val({tag, "_occ"},   {62'd0, occupancy},  64'd0);
      check_val({tag, "_rdy"},   {63'd0, fetch_ready}, 64'd1);
   endtask

   logic [31:0] stream_ins [3] = '{32'h8B020020, 32'h91000421, 32'hD65F03C0};

   initial begin
      reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; decode_ready = 1'b0;
      instruction_in = '0; PC_in = '0; PC_branch_link_in = '0;

      // Reset held two cycles with fetch_valid high
      step(1, 0, 1, 0, 32'h12345678, 64'h40, 64'h44);
      step(1, 0, 1, 0, 32'h12345678, 64'h40, 64'h44);
      check_reset_values("reset");

      // Streaming with decode always ready
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, stream_ins[i], 64'(4 * i), 64'(4 * i + 4));
         check_val("stream_instr", {32'd0, instruction_out}, {32'd0, stream_ins[i]});
         check_val("stream_pc",    PC_out,             64'(4 * i));
         check_val("stream_link",  PC_branch_link_out, 64'(4 * i + 4));
         check_val("stream_occ",   {62'd0, occupancy}, 64'd1);
      end

      // Stall: decode stops while fetch keeps offering
      step(0, 0, 1, 1, 32'hA0000100, 64'h100, 64'h104);
      step(0, 0, 1, 0, 32'hA0000104, 64'h104, 64'h108);
      step(0, 0, 1, 0, 32'hA0000108, 64'h108, 64'h10C);
      step(0, 0, 1, 0, 32'hA0000108, 64'h108, 64'h10C);
      check_val("stall_occ", {62'd0, occupancy},   64'd2);
      check_val("stall_rdy", {63'd0, fetch_ready}, 64'd0);
      check_val("stall_pc",  PC_out,               64'h100);
      step(0, 0, 1, 1, 32'hA0000108, 64'h108, 64'h10C);
      check_val("release_pc1", PC_out, 64'h104);
      check_val("release_rdy", {63'd0, fetch_ready}, 64'd1);
      step(0, 0, 1, 1, 32'hA0000108, 64'h108, 64'h10C);
      check_val("release_pc2", PC_out, 64'h108);

      // Flush while FULL with a same-cycle push
      step(0, 0, 1, 0, 32'hA0000300, 64'h300, 64'h304);
      check_val("pre_flush_occ", {62'd0, occupancy}, 64'd2);
      step(0, 1, 1, 0, 32'hA0000200, 64'h200, 64'h204);
      check_val("flush_valid", {63'd0, valid_out}, 64'd0);
      check_val("flush_occ",   {62'd0, occupancy}, 64'd0);
      check_val("flush_rdy",   {63'd0, fetch_ready}, 64'd1);
      step(0, 0, 1, 1, 32'hA0000400, 64'h400, 64'h404);
      check_val("post_flush_pc", PC_out, 64'h400);

      // Push and pop together in ONE
      step(0, 0, 1, 1, 32'hA0000010, 64'h10, 64'h14);
      step(0, 0, 1, 1, 32'hA0000014, 64'h14, 64'h18);
      check_val("pushpop_pc",  PC_out, 64'h14);
      check_val("pushpop_occ", {62'd0, occupancy}, 64'd1);

      // Flush and reset together while FULL
      step(0, 0, 1, 0, 32'hA0000020, 64'h20, 64'h24);
      check_val("pre_rst_occ", {62'd0, occupancy}, 64'd2);
      step(1, 1, 1, 1, 32'hA0000030, 64'h30, 64'h34);
      check_reset_values("rst_flush");

      // Random traffic, including independent link values
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              $urandom, {$urandom, $urandom}, {$urandom, $urandom});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
